// File: rtl/time_setter.sv
// Time-entry controller: turns debounced button levels into an HH/MM/SS edit
// session and loads the result into the ticker. Optional auto-repeat: TIME_SETTER_AUTOREPEAT_EN.
module time_setter #(
  parameter int SET_HOLD      = 2,
  parameter int REPEAT_DELAY  = 1000000,
  parameter int REPEAT_PERIOD = 200000
) (
  input  logic       clk_2MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic [6:0] curHH,
  input  logic [6:0] curMM,
  input  logic [6:0] curSS,
  output logic       set,
  output logic [6:0] setHH,
  output logic [6:0] setMM,
  output logic [6:0] setSS,
  output logic [1:0] field
);

  localparam int HOLD_W = (SET_HOLD > 1) ? $clog2(SET_HOLD) : 1;
  localparam logic [6:0] HH_MAX = 7'd23;
  localparam logic [6:0] MS_MAX = 7'd59;

  if (SET_HOLD < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("time_setter: SET_HOLD, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_HH,
    S_EDIT_MM,
    S_EDIT_SS,
    S_COMMIT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_mode_prev, r_up_prev, r_down_prev, r_cancel_prev;
  logic              w_mode_p, w_up_p, w_down_p, w_cancel_p;
  logic              w_step_up, w_step_down;
  logic [6:0]        r_hh, r_mm, r_ss;
  logic [6:0]        w_hh_nxt, w_mm_nxt, w_ss_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_set;
  logic [1:0]        r_field;

  function automatic logic [6:0] f_inc(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] f_dec(input logic [6:0] v, input logic [6:0] lim);
    if (v == 7'd0) return lim;
    return (v > lim) ? 7'd0 : v - 7'd1;
  endfunction

  function automatic logic [6:0] f_clamp(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? 7'd0 : v;
  endfunction

  function automatic logic [1:0] f_field(input state_t s);
    case (s)
      S_EDIT_HH: return 2'b01;
      S_EDIT_MM: return 2'b10;
      S_EDIT_SS: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  assign w_mode_p   = btn_mode   & ~r_mode_prev;
  assign w_up_p     = btn_up     & ~r_up_prev;
  assign w_down_p   = btn_down   & ~r_down_prev;
  assign w_cancel_p = btn_cancel & ~r_cancel_prev;

`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
  logic             r_rpt_on, w_rpt_on_nxt;
  logic             w_hold_alone, w_rpt_fire;

  // Counter is 1 on the cycle after the press, so it equals the hold length;
  // after the first repeat it restarts and is compared against the period.
  assign w_hold_alone = (btn_up ^ btn_down) & ~w_mode_p & ~w_cancel_p &
                        (r_state inside {S_EDIT_HH, S_EDIT_MM, S_EDIT_SS});
  assign w_rpt_fire   = w_hold_alone & ~w_up_p & ~w_down_p & (r_rpt_cnt != '0) &
                        (r_rpt_on ? (r_rpt_cnt == RPT_W'(REPEAT_PERIOD))
                                  : (r_rpt_cnt == RPT_W'(REPEAT_DELAY)));

  always_comb begin
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_rpt_on_nxt  = r_rpt_on;
    if (!w_hold_alone) begin
      w_rpt_cnt_nxt = '0;
      w_rpt_on_nxt  = 1'b0;
    end else if (w_up_p || w_down_p) begin
      w_rpt_cnt_nxt = RPT_W'(1);
      w_rpt_on_nxt  = 1'b0;
    end else if (w_rpt_fire) begin
      w_rpt_cnt_nxt = RPT_W'(1);
      w_rpt_on_nxt  = 1'b1;
    end else if (r_rpt_cnt != '0) begin
      w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
    end
  end

  always_ff @(posedge clk_2MHz) begin
    if (!reset) begin
      r_rpt_cnt <= '0;
      r_rpt_on  <= 1'b0;
    end else begin
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_rpt_on  <= w_rpt_on_nxt;
    end
  end

  assign w_step_up   = (w_up_p & ~w_down_p) | (w_rpt_fire & btn_up);
  assign w_step_down = (w_down_p & ~w_up_p) | (w_rpt_fire & btn_down);
`else
  assign w_step_up   = w_up_p & ~w_down_p;
  assign w_step_down = w_down_p & ~w_up_p;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_hh_nxt    = r_hh;
    w_mm_nxt    = r_mm;
    w_ss_nxt    = r_ss;
    w_hold_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_mode_p) begin
          w_hh_nxt    = f_clamp(curHH, HH_MAX);
          w_mm_nxt    = f_clamp(curMM, MS_MAX);
          w_ss_nxt    = f_clamp(curSS, MS_MAX);
          w_state_nxt = S_EDIT_HH;
        end
      end
      S_EDIT_HH, S_EDIT_MM, S_EDIT_SS: begin
        if (w_cancel_p) begin
          w_state_nxt = S_IDLE;
        end else if (w_mode_p) begin
          case (r_state)
            S_EDIT_HH: w_state_nxt = S_EDIT_MM;
            S_EDIT_MM: w_state_nxt = S_EDIT_SS;
            default:   w_state_nxt = S_COMMIT;
          endcase
        end else if (w_step_up || w_step_down) begin
          case (r_state)
            S_EDIT_HH: w_hh_nxt = w_step_up ? f_inc(r_hh, HH_MAX) : f_dec(r_hh, HH_MAX);
            S_EDIT_MM: w_mm_nxt = w_step_up ? f_inc(r_mm, MS_MAX) : f_dec(r_mm, MS_MAX);
            default:   w_ss_nxt = w_step_up ? f_inc(r_ss, MS_MAX) : f_dec(r_ss, MS_MAX);
          endcase
        end
      end
      S_COMMIT: begin
        if (r_hold == HOLD_W'(SET_HOLD - 1)) w_state_nxt = S_IDLE;
        else                                 w_hold_nxt  = r_hold + HOLD_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_2MHz) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_hh          <= '0;
      r_mm          <= '0;
      r_ss          <= '0;
      r_hold        <= '0;
      r_set         <= 1'b0;
      r_field       <= 2'b00;
      // Prev levels reset high so a button held through reset is not a press.
      r_mode_prev   <= 1'b1;
      r_up_prev     <= 1'b1;
      r_down_prev   <= 1'b1;
      r_cancel_prev <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_hh          <= w_hh_nxt;
      r_mm          <= w_mm_nxt;
      r_ss          <= w_ss_nxt;
      r_hold        <= w_hold_nxt;
      r_set         <= (w_state_nxt == S_COMMIT);
      r_field       <= f_field(w_state_nxt);
      r_mode_prev   <= btn_mode;
      r_up_prev     <= btn_up;
      r_down_prev   <= btn_down;
      r_cancel_prev <= btn_cancel;
    end
  end

  assign set   = r_set;
  assign setHH = r_hh;
  assign setMM = r_mm;
  assign setSS = r_ss;
  assign field = r_field;

endmodule
